filt_bank_scheduler: RTL
========================

# filt_bank_scheduler

Two-bank ping-pong scheduler around the disparity filter's BRAM reader/writer. It hands the block-matching producer a bank to fill, swaps banks when the producer finishes a frame, and launches the multi-pass filter on the completed bank. It then publishes the filtered bank to the output streamer and arbitrates between new frames and an in-progress read. It sits between the block-matcher write path, the filter (`start`/`index_in`/`idle`) and the display/USB output reader.

## Interface
- `filt_timeout`, default 2000000: max cycles allowed from filter start acceptance to filter idle; exceeding it sets `err_timeout`.
- `cnt_w`, default 16: width of `frame_cnt` and `drop_cnt`.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `prod_frame_done`  in  1  one-cycle pulse; the producer has finished writing bank `prod_bank`.
- `prod_bank`  out  1  bank the producer writes.
- `filt_start`  out  1  start request to the filter.
- `filt_index`  out  1  bank the filter processes; valid while `filt_start` is high and held through the run.
- `filt_idle`  in  1  filter idle status.
- `cons_req`  in  1  one-cycle pulse; the consumer wants to begin reading a frame.
- `cons_grant`  out  1  one-cycle pulse answering `cons_req` when a frame is ready.
- `cons_bank`  out  1  bank the consumer reads; stable while `cons_busy` is high.
- `cons_busy`  out  1  the consumer holds `cons_bank`.
- `cons_done`  in  1  one-cycle pulse; the consumer has released its bank.
- `frame_ready`  out  1  a filtered frame is available (O_READY).
- `frame_cnt`  out  `cnt_w`  filtered frames completed; wraps.
- `drop_cnt`  out  `cnt_w`  producer frames dropped; saturates at all-ones.
- `err_timeout`  out  1  sticky filter-timeout flag; cleared only by reset.

## Operation
- Bank B = `~prod_bank` is the "other" bank. It has a 2-bit state: O_FREE, O_FSTART, O_FRUN, O_READY.
- **Swap rule.** On `prod_frame_done`, a swap occurs if state is O_FREE, or if state is O_READY and `cons_busy`=0.
  - On a swap: `filt_index` <= `prod_bank`, `prod_bank` toggles, state <= O_FSTART.
  - Otherwise (O_FSTART, O_FRUN, or O_READY with `cons_busy`=1): the frame is dropped, `drop_cnt` increments (saturating), and `prod_bank` is unchanged so the producer overwrites the same bank.
- **O_FSTART.** `filt_start`=1. On the first cycle with `filt_idle`=0: `filt_start` <= 0, state <= O_FRUN, timeout counter cleared.
- **O_FRUN.** The timeout counter increments each cycle.
  - When `filt_idle`=1: state <= O_READY and `frame_cnt` increments.
  - When the counter reaches `filt_timeout`: `err_timeout` <= 1 and state <= O_READY anyway. The frame is published to keep the pipeline alive.
- **O_READY.** `frame_ready`=1.
  - `cons_req` with `cons_busy`=0: `cons_grant` pulses, `cons_bank` <= `filt_index`, `cons_busy` <= 1.
  - `cons_req` in any other state, or while `cons_busy`=1, is ignored: no grant and no error.
- **Consumer release.** `cons_done`: `cons_busy` <= 0. The state stays O_READY so the same frame can be re-read until a swap replaces it.
- **Simultaneous `prod_frame_done` and `cons_req` in O_READY with `cons_busy`=0:** the consumer wins. Grant is issued and the producer frame is dropped.
- **Simultaneous `cons_done` and `prod_frame_done` with `cons_busy`=1:** the producer frame is dropped. Release takes effect next cycle.
- `cons_done` while `cons_busy`=0 is ignored.
- **Reset mid-operation:** all state returns to reset values immediately. The filter is not aborted. The scheduler will not assert `filt_start` again until a new swap occurs.

## Timing
- Reset values:
  - `prod_bank`=0, `filt_index`=1, `cons_bank`=1.
  - `filt_start`=0, `cons_grant`=0, `cons_busy`=0, `frame_ready`=0.
  - `frame_cnt`=0, `drop_cnt`=0, `err_timeout`=0.
  - State=O_FREE.
- All outputs are registered.
- `prod_frame_done` at cycle t (swap): `prod_bank` toggles at t+1; `filt_start`=1 and `filt_index` are valid at t+1.
- `filt_start` stays high until the cycle after `filt_idle` is first sampled low. `filt_index` is held from t+1 until the next swap.
- `filt_idle` sampled high in O_FRUN at cycle u: `frame_ready`=1 and `frame_cnt`+1 at u+1.
- `cons_req` at cycle v (accepted): `cons_grant`=1 and `cons_busy`=1 at v+1; `cons_grant` is low at v+2.
- `cons_done` at cycle w: `cons_busy`=0 at w+1.
- Timeout: `err_timeout` rises `filt_timeout`+1 cycles after entering O_FRUN if `filt_idle` stays low.
- Throughput: one swap per producer frame, provided the filter finishes before the next `prod_frame_done`.

## Test plan
1. **Basic frame.** Release reset, pulse `prod_frame_done`, model the filter dropping `filt_idle` 2 cycles later and raising it 100 cycles after that.
   Expect: `prod_bank`=1; `filt_start` high for 3 cycles with `filt_index`=0; `frame_ready`=1; `frame_cnt`=1.
2. **Drop during filter.** Pulse `prod_frame_done` again while in O_FRUN.
   Expect: `drop_cnt`=1 and `prod_bank` unchanged; after filter completion `frame_cnt`=1.
3. **Consumer hold.** In O_READY, pulse `cons_req`, then `prod_frame_done` while `cons_busy`=1.
   Expect: `cons_grant` once, `cons_bank`=0, frame dropped. After `cons_done`, a later `prod_frame_done` swaps with `filt_index`=1.
4. **Simultaneous events.** Pulse `cons_req` and `prod_frame_done` in the same cycle in O_READY.
   Expect: grant issued and `drop_cnt` increments.
5. **Timeout.** Use `filt_timeout`=50 and hold `filt_idle` low after start acceptance.
   Expect: `err_timeout`=1 at cycle 51 of O_FRUN, `frame_ready`=1, flag stays set until reset.
6. **Reset mid-run and saturation.** Assert `reset_n`=0 in O_FRUN.
   Expect: all outputs at reset values within the same cycle (asynchronous).
   Then, with `cnt_w`=4, force 20 drops: `drop_cnt` holds 15.

Source files
------------

// File: rtl/filt_bank_scheduler_if.sv
// Handshake bundle between the bank scheduler and its three neighbours:
// the block-matching producer, the multi-pass filter and the output reader.
interface filt_bank_scheduler_if;
    // Producer side
    logic prod_frame_done;
    logic prod_bank;
    // Filter side
    logic filt_start;
    logic filt_index;
    logic filt_idle;
    // Consumer side
    logic cons_req;
    logic cons_grant;
    logic cons_bank;
    logic cons_busy;
    logic cons_done;
    logic frame_ready;

    // The scheduler itself
    modport master (
        input  prod_frame_done, filt_idle, cons_req, cons_done,
        output prod_bank, filt_start, filt_index,
               cons_grant, cons_bank, cons_busy, frame_ready
    );

    // Producer, filter and consumer seen as one peer
    modport slave (
        output prod_frame_done, filt_idle, cons_req, cons_done,
        input  prod_bank, filt_start, filt_index,
               cons_grant, cons_bank, cons_busy, frame_ready
    );
endinterface

// File: rtl/filt_bank_scheduler.sv
// Two-bank ping-pong scheduler. The producer always writes prod_bank; the
// other bank walks FREE -> FSTART -> FRUN -> READY, is filtered and then
// published to the consumer. A producer frame that finishes while the other
// bank is still busy is dropped and the producer overwrites its own bank.
module filt_bank_scheduler #(
    parameter int unsigned filt_timeout = 2000000,
    parameter int unsigned cnt_w        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    filt_bank_scheduler_if.master bus,
    output logic [cnt_w-1:0]      frame_cnt,
    output logic [cnt_w-1:0]      drop_cnt,
    output logic                  err_timeout
);
    localparam int unsigned TMO_W = (filt_timeout < 1) ? 1 : $clog2(filt_timeout + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(filt_timeout);

    typedef enum logic [1:0] {
        O_FREE   = 2'd0,
        O_FSTART = 2'd1,
        O_FRUN   = 2'd2,
        O_READY  = 2'd3
    } obank_state_t;

    obank_state_t     state_q, state_d;
    logic             prod_bank_q, prod_bank_d;
    logic             filt_index_q, filt_index_d;
    logic             filt_start_q, filt_start_d;
    logic             cons_bank_q, cons_bank_d;
    logic             cons_busy_q, cons_busy_d;
    logic             cons_grant_q, cons_grant_d;
    logic             frame_ready_q, frame_ready_d;
    logic [cnt_w-1:0] frame_cnt_q, frame_cnt_d;
    logic [cnt_w-1:0] drop_cnt_q, drop_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             cons_accept;
    logic             swap_ok;

    // Next-state logic: consumer arbitration, filter sequencing, producer swap
    always_comb begin
        state_d       = state_q;
        prod_bank_d   = prod_bank_q;
        filt_index_d  = filt_index_q;
        cons_bank_d   = cons_bank_q;
        cons_busy_d   = cons_busy_q;
        cons_grant_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        err_timeout_d = err_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;

        // A read request is honoured only on a published, unclaimed frame;
        // it beats a simultaneous producer swap.
        cons_accept = bus.cons_req && (state_q == O_READY) && !cons_busy_q;
        swap_ok     = (state_q == O_FREE) ||
                      ((state_q == O_READY) && !cons_busy_q && !cons_accept);

        if (cons_accept) begin
            cons_grant_d = 1'b1;
            cons_bank_d  = filt_index_q;
            cons_busy_d  = 1'b1;
        end else if (bus.cons_done && cons_busy_q) begin
            cons_busy_d  = 1'b0;
        end

        case (state_q)
            O_FSTART: begin
                // The filter has taken the request once it leaves idle
                if (!bus.filt_idle) begin
                    state_d   = O_FRUN;
                    tmo_cnt_d = '0;
                end
            end
            O_FRUN: begin
                if (bus.filt_idle) begin
                    state_d     = O_READY;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    // Publish anyway so the pipeline keeps moving
                    state_d       = O_READY;
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (bus.prod_frame_done) begin
            if (swap_ok) begin
                filt_index_d = prod_bank_q;
                prod_bank_d  = ~prod_bank_q;
                state_d      = O_FSTART;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end

        filt_start_d  = (state_d == O_FSTART);
        frame_ready_d = (state_d == O_READY);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= O_FREE;
            prod_bank_q   <= 1'b0;
            filt_index_q  <= 1'b1;
            filt_start_q  <= 1'b0;
            cons_bank_q   <= 1'b1;
            cons_busy_q   <= 1'b0;
            cons_grant_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            prod_bank_q   <= prod_bank_d;
            filt_index_q  <= filt_index_d;
            filt_start_q  <= filt_start_d;
            cons_bank_q   <= cons_bank_d;
            cons_busy_q   <= cons_busy_d;
            cons_grant_q  <= cons_grant_d;
            frame_ready_q <= frame_ready_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            err_timeout_q <= err_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.prod_bank   = prod_bank_q;
    assign bus.filt_start  = filt_start_q;
    assign bus.filt_index  = filt_index_q;
    assign bus.cons_bank   = cons_bank_q;
    assign bus.cons_busy   = cons_busy_q;
    assign bus.cons_grant  = cons_grant_q;
    assign bus.frame_ready = frame_ready_q;
    assign frame_cnt       = frame_cnt_q;
    assign drop_cnt        = drop_cnt_q;
    assign err_timeout     = err_timeout_q;
endmodule
